pdm_cic_decimator: RTL



---
 rtl/audio_pkg.sv | 13 +
 rtl/pdm_clk_gen.sv | 35 +++
 rtl/pdm_cic_decimator.sv | 112 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: PCM sample type and saturation helper shared by the audio input chain
//   PCM_W   : PCM sample width
//   pcm_t   : signed PCM sample
//   sat_pcm : clamp a wide signed value into the pcm_t range
package audio_pkg;
   localparam int PCM_W = 16;
   typedef logic signed [PCM_W-1:0] pcm_t;
   localparam logic signed [63:0] PCM_MAX = (64'sd1 <<< (PCM_W-1)) - 64'sd1;
   localparam logic signed [63:0] PCM_MIN = -(64'sd1 <<< (PCM_W-1));
   function automatic pcm_t sat_pcm(input logic signed [63:0] x);
      return x > PCM_MAX ? PCM_MAX[PCM_W-1:0] : x < PCM_MIN ? PCM_MIN[PCM_W-1:0] : x[PCM_W-1:0];
   endfunction
endpackage

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen: PDM microphone clock divider and bit-sample strobe
//   clk       : system clock
//   reset     : synchronous active-high reset
//   enable_i  : 0 freezes the divider count and holds pdm_clk_o low
//   pdm_clk_o : clk/CLK_DIV, high for counts 0..CLK_DIV/2-1
//   bit_stb_o : one-cycle strobe on the last low-phase count, just before pdm_clk_o rises
module pdm_clk_gen #(
   parameter int CLK_DIV = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic enable_i,
   output logic pdm_clk_o,
   output logic bit_stb_o
);
   localparam int CW = $clog2(CLK_DIV);
   logic [CW-1:0] cnt_q, cnt_d;
   logic pdm_clk_q, pdm_clk_d;
   always_comb begin
      cnt_d = enable_i ? (cnt_q == CW'(CLK_DIV-1) ? '0 : cnt_q + 1'b1) : cnt_q;
      // Registered from the next count so pdm_clk tracks the count without a combinational output.
      pdm_clk_d = enable_i && (cnt_d < CW'(CLK_DIV/2));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         pdm_clk_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pdm_clk_q <= pdm_clk_d;
      end
   end
   assign pdm_clk_o = pdm_clk_q;
   assign bit_stb_o = enable_i && cnt_q == CW'(CLK_DIV-1);
endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: PDM capture and N-stage CIC decimate-by-DECIM to signed PCM
//   clk, reset : system clock, synchronous active-high reset
//   enable     : 0 holds pdm_clk low and freezes the filter; the output handshake still completes
//   pdm_clk    : microphone clock, clk/CLK_DIV
//   pdm_data   : microphone bit, sampled just before each pdm_clk rising edge
//   out_data   : saturated signed PCM sample, valid while out_valid=1
//   out_valid  : out_data holds an unconsumed sample
//   out_ready  : downstream accepts the sample
//   overrun    : sticky, a sample overwrote an unconsumed one
module pdm_cic_decimator
   import audio_pkg::*;
#(
   parameter int CLK_DIV  = 8,
   parameter int DECIM    = 32,
   parameter int N_STAGES = 4,
   parameter int OUT_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   output logic                    pdm_clk,
   input  logic                    pdm_data,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun
);
   localparam int LR    = $clog2(DECIM);
   localparam int W     = 2 + N_STAGES*LR;
   localparam int SHIFT = N_STAGES*LR - (OUT_W-1);
   localparam logic signed [W-1:0] P1 = W'(1);
   localparam logic signed [W-1:0] M1 = W'(-1);
   logic bit_stb, wrap, dec_stb_q, load;
   logic [LR-1:0] dec_cnt_q;
   logic signed [W-1:0] int_q [N_STAGES];
   logic signed [W-1:0] int_d [N_STAGES];
   logic signed [W-1:0] comb_q [N_STAGES];
   logic signed [W-1:0] dly_q [N_STAGES];
   logic signed [W-1:0] comb_in [N_STAGES];
   logic signed [W-1:0] samp_q, scaled;
   logic [N_STAGES-1:0] stg_v_q, v_in;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic out_valid_q, out_valid_d, overrun_q, overrun_d;
   pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk      (clk),
      .reset    (reset),
      .enable_i (enable),
      .pdm_clk_o(pdm_clk),
      .bit_stb_o(bit_stb)
   );
   // Integrators chain through next-state values so the decimated output includes the current bit.
   for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign int_d[k]   = int_q[k] + (pdm_data ? P1 : M1);
         assign comb_in[k] = samp_q;
      end else begin : g_next
         assign int_d[k]   = int_q[k] + int_d[k-1];
         assign comb_in[k] = comb_q[k-1];
      end
   end
   assign wrap   = dec_cnt_q == LR'(DECIM-1);
   assign v_in   = (stg_v_q << 1) | N_STAGES'(dec_stb_q);
   assign scaled = comb_q[N_STAGES-1] >>> SHIFT;
   assign load   = enable && stg_v_q[N_STAGES-1];
   always_ff @(posedge clk) begin
      if (reset) begin
         dec_cnt_q <= '0;
         dec_stb_q <= 1'b0;
         samp_q    <= '0;
         stg_v_q   <= '0;
         for (int i = 0; i < N_STAGES; i++) begin
            int_q[i]  <= '0;
            comb_q[i] <= '0;
            dly_q[i]  <= '0;
         end
      end else if (enable) begin
         dec_stb_q <= bit_stb && wrap;
         stg_v_q   <= v_in;
         if (bit_stb) begin
            dec_cnt_q <= dec_cnt_q + 1'b1;
            for (int i = 0; i < N_STAGES; i++) int_q[i] <= int_d[i];
            if (wrap) samp_q <= int_d[N_STAGES-1];
         end
         // Each comb fires as the decimated strobe ripples through, one stage per clk.
         for (int i = 0; i < N_STAGES; i++) begin
            if (v_in[i]) begin
               comb_q[i] <= comb_in[i] - dly_q[i];
               dly_q[i]  <= comb_in[i];
            end
         end
      end
   end
   always_comb begin
      out_data_d  = load ? OUT_W'(sat_pcm(64'(scaled))) : out_data_q;
      out_valid_d = load || (out_valid_q && !out_ready);
      overrun_d   = overrun_q || (load && out_valid_q && !out_ready);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;
endmodule
